// File: rtl/if_id_queue_if.sv
// Valid/ready handshake bundle carrying one fetched instruction {pc, inst, exc}.
// The master drives the payload and valid; the slave answers with ready.
interface if_id_queue_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 32
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic [EXC_W-1:0]  exc;

  modport master (output valid, pc, inst, exc, input ready);
  modport slave  (input valid, pc, inst, exc, output ready);
endinterface

// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: a DEPTH-entry circular queue of {pc, inst, exc}
// with flush (empty everything) and kill (drop incoming fetch) controls.
module if_id_queue #(
  parameter  int PC_W   = 32,
  parameter  int INST_W = 32,
  parameter  int EXC_W  = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              kill_i,
  if_id_queue_if.slave      in_if,
  if_id_queue_if.master     out_if,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [EXC_W-1:0]  exc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Ready comes from registered occupancy only, so a pop never frees a slot
  // for a same-cycle push while full.
  assign in_if.ready = (count < DEPTH_C);
  assign count_o     = count;
  assign full_o      = (count == DEPTH_C);

  assign push = in_if.valid & in_if.ready & ~kill_i & ~flush_i;
  assign pop  = out_if.valid & out_if.ready & ~flush_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only
  // observable after being written, and count masks stale contents.
  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= '{pc: in_if.pc, inst: in_if.inst, exc: in_if.exc};
  end

  // NOTE: outputs get a default before the conditional so no latch is inferred.
  always_comb begin
    out_if.valid = 1'b0;
    out_if.pc    = '0;
    out_if.inst  = '0;
    out_if.exc   = '0;
    if (count != '0) begin
      out_if.valid = 1'b1;
      out_if.pc    = mem[rd_ptr].pc;
      out_if.inst  = mem[rd_ptr].inst;
      out_if.exc   = mem[rd_ptr].exc;
    end
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised fetch-to-decode pipeline buffer between the post-IF stage and ID.
- Replaces the single-entry register with its one-slot PC buffer by a DEPTH-entry circular queue of {pc, inst, exception_type} with valid/ready handshakes on both sides.
- Absorbs ID/EXE/MEM back-pressure without losing fetched instructions, and supports full flush (exception) and kill of the incoming fetch (taken branch).
- Presents zeroed bubbles to ID when empty.

Parameters:
PC_W, 32, PC width
INST_W, 32, instruction width
EXC_W, 32, exception_type width
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clock_i  in  1  clock, all state on posedge
reset_i  in  1  synchronous, active-high reset
flush_i  in  1  exception flush; empties queue and discards current input
kill_i  in  1  branch kill; discards current input only, queued entries kept
in_valid_i  in  1  post-IF instruction valid
in_ready_o  out  1  queue can accept this cycle
in_pc_i  in  PC_W  fetched PC
in_inst_i  in  INST_W  fetched instruction
in_exc_i  in  EXC_W  fetch exception type
out_valid_o  out  1  head entry valid for ID
out_ready_i  in  1  ID consumes head (ID not stalled)
out_pc_o  out  PC_W  head PC, 0 when empty
out_inst_o  out  INST_W  head instruction, 0 when empty
out_exc_o  out  EXC_W  head exception type, 0 when empty
count_o  out  CNT_W  current occupancy
full_o  out  1  count_o == DEPTH

Behaviour:
- Storage: DEPTH-entry register array; wr_ptr and rd_ptr of log2(DEPTH) bits wrap modulo DEPTH; count register of CNT_W bits.
- Reset (reset_i=1 at posedge): wr_ptr=rd_ptr=0, count=0. Consequently out_valid_o=0, out_pc_o/out_inst_o/out_exc_o=0, count_o=0, full_o=0, in_ready_o=1. Array contents need no reset.
- in_ready_o = (count < DEPTH). Depends on registered state only; no combinational path from out_ready_i. A pop in the same cycle does not free a slot for a push while full.
- push = in_valid_i & in_ready_o & ~kill_i & ~flush_i. It writes {pc, inst, exc} at wr_ptr and increments wr_ptr.
- pop = out_valid_o & out_ready_i & ~flush_i. It increments rd_ptr.
- count next: push&~pop -> +1; pop&~push -> -1; both or neither -> unchanged.
- Outputs are driven from the head entry (rd_ptr) when count != 0; otherwise forced to zero, giving a bubble.
- Latency: an entry pushed at edge N is visible on the outputs after edge N if the queue was empty. Outputs are never driven combinationally from in_*.
- flush_i=1 at posedge: wr_ptr=rd_ptr=0 and count=0, regardless of in_valid_i, kill_i or out_ready_i. flush_i has priority over every other event except reset_i, and reset_i has priority over flush_i.
- kill_i=1: the current input is dropped even if in_valid_i=1. Queue contents and pop are unaffected.
- Full with pop: count goes DEPTH -> DEPTH-1 and in_ready_o rises the next cycle.
- Empty with out_ready_i=1: no pop, count stays 0 (no underflow).
- Pointers wrap from DEPTH-1 to 0 with no special case. Order is strictly FIFO across the wrap.
- out_ready_i=0 holds the head entry stable on all outputs for any number of cycles.

Test Plan:
- Reset then idle: assert reset_i for 2 cycles -> all outputs 0, in_ready_o=1, count_o=0.
- Single pass: push pc=0xBFC00000, inst=0x3C080001, exc=0 with out_ready_i=1 -> next cycle out_valid_o=1 with those exact values; following cycle out_valid_o=0 and outputs 0.
- Back-pressure fill: out_ready_i=0, push PCs 0xBFC00000..0xBFC0000C (DEPTH=4) -> count_o=4, full_o=1, in_ready_o=0; a 5th push is ignored. Release out_ready_i -> the four PCs drain in order, one per cycle.
- Wrap-around: interleave pushes and pops so 10 entries pass through DEPTH=4 with count oscillating 1..3 -> output PC sequence equals input sequence exactly.
- Kill: with 2 entries queued, in_valid_i=1 and kill_i=1 for pc=0xBFC00020 -> count_o stays 2 and 0xBFC00020 never appears on out_pc_o.
- Flush priority: with 3 entries queued, assert flush_i together with push and pop in the same cycle -> next cycle count_o=0, out_valid_o=0, outputs 0. Then push pc=0xBFC00380 -> it appears next cycle as the head.
